// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared encodings for the MEM stage of the MIPS pipeline
//
// Purpose: RegDst / MemtoReg encodings, MEM-stage FSM state enum and MIPS
// instruction field positions used by mem_access_stage.
// Ports: none (package).

package pipeline_pkg;

  // RegDst select values
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // MemtoReg select values
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  // Instruction register field positions
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  // jal link register
  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble insertion
//
// Purpose: holds the write-back control and data launched by the MEM stage.
// Ports:
//   clk, reset (async active-low)
//   bubble       : load zeros instead of the incoming values
//   regwrite_in, wreg_in, data_in : values to capture
//   wb_regwrite, wb_wreg, wb_data : registered MEM/WB contents

module mem_wb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic        regwrite_in,
  input  logic [4:0]  wreg_in,
  input  logic [31:0] data_in,
  output logic        wb_regwrite,
  output logic [4:0]  wb_wreg,
  output logic [31:0] wb_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_regwrite <= 1'b0;
      wb_wreg     <= 5'd0;
      wb_data     <= 32'd0;
    end else if (bubble) begin
      wb_regwrite <= 1'b0;
      wb_wreg     <= 5'd0;
      wb_data     <= 32'd0;
    end else begin
      wb_regwrite <= regwrite_in;
      wb_wreg     <= wreg_in;
      wb_data     <= data_in;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory handshake, stall, MEM/WB launch
//
// Purpose: drives a ready-handshaked data-memory port for lw/sw from the
// EX/MEM register, stalls upstream while an access is outstanding, aborts
// misaligned or timed-out accesses with a one-cycle fault pulse, and loads
// the MEM/WB register.
// Ports:
//   clk, reset (async active-low)
//   ir_in, pc_plus_4_in, alu_out_in, regb_in, regwrite_in, memread_in,
//   memwrite_in, regdst_in, memtoreg_in : EX/MEM register contents
//   dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_ready, dmem_rdata : data memory port
//   mem_stall : hold PC, IF/ID, ID/EX, EX/MEM
//   mem_fault : one-cycle abort pulse
//   wb_regwrite, wb_wreg, wb_data : MEM/WB register outputs

module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] regb_in,
  input  logic        regwrite_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic [1:0]  regdst_in,
  input  logic [1:0]  memtoreg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        wb_regwrite,
  output logic [4:0]  wb_wreg,
  output logic [31:0] wb_data
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  mem_state_e     state;
  logic [CW-1:0]  wait_cnt;
  logic           memop;
  logic           misaligned;
  logic           timeout_now;
  logic [4:0]     wreg;
  logic [31:0]    sel_data;
  logic           bubble;
  logic           unused_ir;

  assign memop       = memread_in | memwrite_in;
  assign misaligned  = memop & (alu_out_in[1:0] != 2'b00);
  assign dmem_req    = memop & ~misaligned;
  assign dmem_we     = memwrite_in & ~memread_in;
  assign dmem_addr   = alu_out_in;
  assign dmem_wdata  = regb_in;

  // wait_cnt holds the number of cycles the request has already been held,
  // so the abort lands on the TIMEOUT-th cycle of the request.
  assign timeout_now = (state == ST_WAIT) & (wait_cnt == CW'(TIMEOUT - 1)) & ~dmem_ready;
  assign mem_stall   = dmem_req & ~dmem_ready & ~timeout_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= misaligned | timeout_now;
      case (state)
        ST_IDLE: begin
          if (dmem_req & ~dmem_ready) begin
            state    <= ST_WAIT;
            wait_cnt <= CW'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          // A dropped request cannot happen while stalled, but leaving WAIT
          // keeps the FSM from hanging if it ever does.
          if (dmem_ready | timeout_now | ~dmem_req) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    wreg = 5'd0;
    case (regdst_in)
      REGDST_RT: wreg = ir_in[RT_MSB:RT_LSB];
      REGDST_RD: wreg = ir_in[RD_MSB:RD_LSB];
      REGDST_RA: wreg = REG_RA;
      default:   wreg = 5'd0;
    endcase
  end

  always_comb begin
    sel_data = 32'd0;
    case (memtoreg_in)
      M2R_ALU: sel_data = alu_out_in;
      M2R_MEM: sel_data = dmem_rdata;
      M2R_PC4: sel_data = pc_plus_4_in;
      default: sel_data = 32'd0;
    endcase
  end

  assign bubble    = mem_stall | misaligned | timeout_now;
  assign unused_ir = ^{ir_in[31:21], ir_in[10:0]};

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .bubble      (bubble),
    .regwrite_in (regwrite_in & (wreg != 5'd0)),
    .wreg_in     (wreg),
    .data_in     (sel_data),
    .wb_regwrite (wb_regwrite),
    .wb_wreg     (wb_wreg),
    .wb_data     (wb_data)
  );

endmodule
